div_ctrl: RTL and testbench

Sequencer for the multi-cycle DIV/DIVU path in the execute stage. It accepts one divide request, runs a 32-iteration restoring division on operand magnitudes, applies the MIPS sign rules and delivers a 64-bit {remainder, quotient} result. It holds the pipeline stalled while busy and aborts cleanly on an exception flush. Signed versus unsigned treatment is selected per instruction, in the same way the execute stage selects sign versus zero extension of immediates.

---
 rtl/div_ctrl_if.sv | 31 +++
 rtl/div_ctrl.sv | 162 ++++++++++++++++
 tb/tb_div_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/div_ctrl_if.sv
// div_ctrl_if
// Request/result bundle between the execute stage and the divide sequencer.
//   start_i   : divide request, held until the result is consumed
//   signed_i  : 1 = DIV, 0 = DIVU (used at accept only)
//   opdata1_i : dividend (used at accept only)
//   opdata2_i : divisor  (used at accept only)
//   annul_i   : flush/exception abort
//   result_o  : {remainder, quotient}
//   ready_o   : result valid
//   stall_o   : combinational stall request to pipeline control
// master = execute stage side, slave = divider side.
interface div_ctrl_if;
    logic        start_i;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stall_o;

    modport master (
        output start_i, signed_i, opdata1_i, opdata2_i, annul_i,
        input  result_o, ready_o, stall_o
    );

    modport slave (
        input  start_i, signed_i, opdata1_i, opdata2_i, annul_i,
        output result_o, ready_o, stall_o
    );
endinterface

// File: rtl/div_ctrl.sv
// div_ctrl
// Multi-cycle DIV/DIVU sequencer: 32-iteration restoring division on operand
// magnitudes, MIPS sign fix-up, pipeline stall while busy, abort on flush.
// Ports:
//   clk    : rising-edge clock
//   resetn : synchronous reset, active low
//   bus    : div_ctrl_if.slave (request, operands, annul, result, ready, stall)
//
// state   | meaning
// --------+-----------------------------------------------------------
// FREE    | idle, waiting for start_i with annul_i low
// DIVZERO | divisor was zero, result forced to zero on exit
// ON      | one restoring-division iteration per cycle, 32 cycles
// END     | result valid, held while start_i stays high
module div_ctrl (
    input  logic        clk,
    input  logic        resetn,
    div_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        DIVZERO = 2'd1,
        ON      = 2'd2,
        END     = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [4:0]  r_cnt;
    // Partial remainder after an iteration is always below the divisor, so
    // 32 bits hold it; the 33rd bit only exists transiently after the shift.
    logic [31:0] r_rem;
    // Dividend and quotient share one register: dividend MSBs shift out
    // while quotient bits shift in at the bottom.
    logic [31:0] r_dq;
    logic [31:0] r_divisor;
    // Operand signs are stored already masked by signed_i, so DIVU never
    // triggers a fix-up.
    logic        r_sign_a;
    logic        r_sign_b;
    logic [63:0] r_result;
    logic        r_ready;

    logic        w_accept;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [32:0] w_rem_sh;
    logic        w_ge;
    logic [31:0] w_sub;
    logic [31:0] w_rem_nx;
    logic [31:0] w_dq_nx;
    logic [31:0] w_quot_fix;
    logic [31:0] w_rem_fix;

    assign w_accept = (r_state == FREE) && bus.start_i && !bus.annul_i;

    // Negating 0x80000000 leaves 0x80000000, which read unsigned is 2^31.
    assign w_mag_a = (bus.signed_i && bus.opdata1_i[31]) ? -bus.opdata1_i : bus.opdata1_i;
    assign w_mag_b = (bus.signed_i && bus.opdata2_i[31]) ? -bus.opdata2_i : bus.opdata2_i;

    assign w_rem_sh = {r_rem, r_dq[31]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_divisor});
    // When w_ge holds the true difference is below the divisor, so a 32-bit
    // subtract is exact.
    assign w_sub    = w_rem_sh[31:0] - r_divisor;
    assign w_rem_nx = w_ge ? w_sub : w_rem_sh[31:0];
    assign w_dq_nx  = {r_dq[30:0], w_ge};

    assign w_quot_fix = (r_sign_a ^ r_sign_b) ? -w_dq_nx  : w_dq_nx;
    assign w_rem_fix  = r_sign_a              ? -w_rem_nx : w_rem_nx;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= FREE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            FREE: begin
                if (w_accept) begin
                    w_next = (bus.opdata2_i == 32'd0) ? DIVZERO : ON;
                end
            end
            DIVZERO: begin
                w_next = bus.annul_i ? FREE : END;
            end
            ON: begin
                if (bus.annul_i) begin
                    w_next = FREE;
                end else if (r_cnt == 5'd31) begin
                    w_next = END;
                end
            end
            END: begin
                if (bus.annul_i || !bus.start_i) begin
                    w_next = FREE;
                end
            end
            default: w_next = FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt     <= 5'd0;
            r_rem     <= 32'd0;
            r_dq      <= 32'd0;
            r_divisor <= 32'd0;
            r_sign_a  <= 1'b0;
            r_sign_b  <= 1'b0;
            r_result  <= 64'd0;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                FREE: begin
                    if (w_accept) begin
                        r_sign_a  <= bus.signed_i & bus.opdata1_i[31];
                        r_sign_b  <= bus.signed_i & bus.opdata2_i[31];
                        r_dq      <= w_mag_a;
                        r_divisor <= w_mag_b;
                        r_rem     <= 32'd0;
                        r_cnt     <= 5'd0;
                    end
                end
                DIVZERO: begin
                    if (!bus.annul_i) begin
                        r_result <= 64'd0;
                        r_ready  <= 1'b1;
                    end
                end
                ON: begin
                    if (!bus.annul_i) begin
                        r_rem <= w_rem_nx;
                        r_dq  <= w_dq_nx;
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == 5'd31) begin
                            r_result <= {w_rem_fix, w_quot_fix};
                            r_ready  <= 1'b1;
                        end
                    end
                end
                END: begin
                    if (bus.annul_i || !bus.start_i) begin
                        r_ready <= 1'b0;
                    end
                end
                default: r_ready <= 1'b0;
            endcase
        end
    end

    assign bus.result_o = r_result;
    assign bus.ready_o  = r_ready;
    assign bus.stall_o  = w_accept || (r_state == DIVZERO) || (r_state == ON);

endmodule

// File: tb/tb_div_ctrl.sv
module tb_div_ctrl;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    div_ctrl_if u_if ();

    div_ctrl u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (u_if.slave)
    );

    typedef struct {
        bit          sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          hold;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    // Reference: 64-bit arithmetic avoids the 0x80000000 / -1 overflow;
    // SV division truncates toward zero and % follows the dividend sign,
    // which matches the MIPS rules.
    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a,
                                            input logic [31:0] b);
        longint x, y, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'd0, a});
            y = longint'({32'd0, b});
        end
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request, checks stall profile, latency and result, holds
    // start_i for `hold` extra END cycles, then releases it.
    task automatic run_div(input string nm, input bit sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int hold);
        int lat_exp;
        int cyc;
        int stall_bad;
        int hold_bad;
        bit timed_out;
        lat_exp   = (b == 32'd0) ? 2 : 33;
        cyc       = 0;
        stall_bad = 0;
        hold_bad  = 0;
        timed_out = 0;
        u_if.start_i   = 1'b1;
        u_if.signed_i  = sgn;
        u_if.opdata1_i = a;
        u_if.opdata2_i = b;
        u_if.annul_i   = 1'b0;
        #1;
        chk({nm, " stall_c0"}, {63'd0, u_if.stall_o}, 64'd1);
        while (1) begin
            tick();
            cyc++;
            // Operand changes after accept must be ignored.
            u_if.signed_i  = $urandom_range(0, 1);
            u_if.opdata1_i = $urandom;
            u_if.opdata2_i = $urandom;
            #1;
            if (u_if.ready_o === 1'b1) break;
            if (u_if.stall_o !== 1'b1) stall_bad++;
            if (cyc > 60) begin
                timed_out = 1;
                break;
            end
        end
        chk({nm, " timeout"}, {63'd0, timed_out}, 64'd0);
        chk({nm, " latency"}, 64'(cyc), 64'(lat_exp));
        chk({nm, " stall_busy"}, 64'(stall_bad), 64'd0);
        chk({nm, " stall_end"}, {63'd0, u_if.stall_o}, 64'd0);
        chk({nm, " result"}, u_if.result_o, exp);
        for (int i = 0; i < hold; i++) begin
            tick();
            if (u_if.ready_o !== 1'b1 || u_if.result_o !== exp) hold_bad++;
        end
        if (hold > 0) chk({nm, " hold"}, 64'(hold_bad), 64'd0);
        u_if.start_i = 1'b0;
        tick();
        chk({nm, " ready_drop"}, {63'd0, u_if.ready_o}, 64'd0);
        chk({nm, " result_keep"}, u_if.result_o, exp);
    endtask

    initial begin
        logic [63:0] prev;
        logic [31:0] ra, rb;
        bit          rs;
        int          bad;

        vecs[0] = '{1'b0, 32'd100,        32'd7,        64'h00000002_0000000E, 0};
        vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,        64'hFFFFFFFF_FFFFFFFD, 0};
        vecs[2] = '{1'b0, 32'hFFFFFFF9,   32'd2,        64'h00000001_7FFFFFFC, 0};
        vecs[3] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000, 0};
        vecs[4] = '{1'b0, 32'd1234,       32'd0,        64'h00000000_00000000, 0};
        vecs[5] = '{1'b0, 32'd0,          32'd5,        64'h00000000_00000000, 0};
        vecs[6] = '{1'b0, 32'hFFFFFFFF,   32'd1,        64'h00000000_FFFFFFFF, 0};
        vecs[7] = '{1'b1, 32'd7,          32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 0};
        vecs[8] = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE, 64'hFFFFFFFF_00000003, 0};
        vecs[9] = '{1'b0, 32'hFFFFFFFF,   32'h10,       64'h0000000F_0FFFFFFF, 5};

        u_if.start_i   = 1'b0;
        u_if.signed_i  = 1'b0;
        u_if.opdata1_i = 32'd0;
        u_if.opdata2_i = 32'd0;
        u_if.annul_i   = 1'b0;
        resetn = 1'b0;
        tick();
        tick();
        chk("reset result", u_if.result_o, 64'd0);
        chk("reset ready", {63'd0, u_if.ready_o}, 64'd0);
        chk("reset stall", {63'd0, u_if.stall_o}, 64'd0);
        resetn = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_div($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b,
                    vecs[i].exp, vecs[i].hold);
        end

        // annul_i and start_i together in FREE: no accept, no stall.
        u_if.start_i = 1'b1;
        u_if.annul_i = 1'b1;
        #1;
        chk("annul_free stall", {63'd0, u_if.stall_o}, 64'd0);
        tick();
        chk("annul_free stall2", {63'd0, u_if.stall_o}, 64'd0);
        u_if.start_i = 1'b0;
        u_if.annul_i = 1'b0;
        tick();

        // Abort at ON cycle 10.
        prev = 64'h0000000F_0FFFFFFF;
        u_if.start_i   = 1'b1;
        u_if.signed_i  = 1'b0;
        u_if.opdata1_i = 32'd1000;
        u_if.opdata2_i = 32'd3;
        for (int i = 0; i < 10; i++) tick();
        chk("annul_on stall", {63'd0, u_if.stall_o}, 64'd1);
        u_if.annul_i = 1'b1;
        tick();
        chk("annul_on free_stall", {63'd0, u_if.stall_o}, 64'd0);
        u_if.start_i = 1'b0;
        u_if.annul_i = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (u_if.ready_o !== 1'b0 || u_if.stall_o !== 1'b0) bad++;
        end
        chk("annul_on quiet", 64'(bad), 64'd0);
        chk("annul_on result_keep", u_if.result_o, prev);
        run_div("after_annul", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 0);

        // Abort while in DIVZERO.
        u_if.start_i   = 1'b1;
        u_if.opdata1_i = 32'd5;
        u_if.opdata2_i = 32'd0;
        tick();
        u_if.annul_i = 1'b1;
        tick();
        chk("annul_dz ready", {63'd0, u_if.ready_o}, 64'd0);
        chk("annul_dz result", u_if.result_o, 64'h00000000_00000003);
        u_if.start_i = 1'b0;
        u_if.annul_i = 1'b0;
        tick();
        tick();
        chk("annul_dz ready2", {63'd0, u_if.ready_o}, 64'd0);

        // Abort while in END.
        u_if.start_i   = 1'b1;
        u_if.signed_i  = 1'b1;
        u_if.opdata1_i = 32'hFFFFFF9C;
        u_if.opdata2_i = 32'd10;
        for (int i = 0; i < 33; i++) tick();
        chk("annul_end ready", {63'd0, u_if.ready_o}, 64'd1);
        chk("annul_end result", u_if.result_o, 64'h00000000_FFFFFFF6);
        u_if.annul_i = 1'b1;
        tick();
        chk("annul_end drop", {63'd0, u_if.ready_o}, 64'd0);
        u_if.start_i = 1'b0;
        u_if.annul_i = 1'b0;
        tick();

        // Randomized operations against the reference model.
        for (int n = 0; n < 60; n++) begin
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       ra = 32'h80000000;
                1:       ra = 32'($urandom_range(0, 100));
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 9))
                0:       rb = 32'd0;
                1, 2:    rb = 32'($urandom_range(1, 15));
                3:       rb = -32'($urandom_range(1, 15));
                4:       rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            run_div($sformatf("rnd%0d", n), rs, ra, rb, ref_div(rs, ra, rb), 0);
        end

        // Reset in the middle of ON.
        u_if.start_i   = 1'b1;
        u_if.signed_i  = 1'b0;
        u_if.opdata1_i = 32'd77;
        u_if.opdata2_i = 32'd5;
        for (int i = 0; i < 6; i++) tick();
        resetn       = 1'b0;
        u_if.start_i = 1'b0;
        tick();
        chk("rst_mid result", u_if.result_o, 64'd0);
        chk("rst_mid ready", {63'd0, u_if.ready_o}, 64'd0);
        chk("rst_mid stall", {63'd0, u_if.stall_o}, 64'd0);
        resetn = 1'b1;
        tick();
        run_div("after_rst", 1'b0, 32'd77, 32'd5, 64'h00000002_0000000F, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
